// File: rtl/spi_master_seq.sv
// -----------------------------------------------------------------------------
// spi_master_seq
//
// Host-side SPI sequencer. Takes one 10-bit command ({op, payload}) at a time
// over a valid/ready port and serialises it as a complete slave frame. The bit
// clock is clk itself, so one bit goes out per cycle. For read-data commands
// (op == 2'b11) it waits RD_WAIT cycles, samples 8 MISO bits MSB first and
// returns the byte with a one-cycle rsp_valid strobe.
//
// Frame: IDLE -> SEL -> CMD -> SHIFT -> (read-data ? WAIT -> CAPT : HOLD)
//        -> GAP -> IDLE
//
// Ports:
//   clk        system clock, also the SPI bit clock
//   rst_n      synchronous active-low reset
//   req_valid  command present
//   req_ready  block idle and able to accept (state == IDLE)
//   req_op     00 write-addr, 01 write-data, 10 read-addr, 11 read-data
//   req_data   address or data payload
//   rsp_valid  one-cycle pulse, rsp_data carries a fresh read byte
//   rsp_data   last byte captured from MISO, held between responses
//   busy       high whenever a frame is in progress
//   ss_n       slave select, active low, registered
//   mosi       serial data to the slave, registered
//   miso       serial data from the slave, synchronous to clk
// -----------------------------------------------------------------------------
module spi_master_seq #(
  parameter int RD_WAIT = 3,
  parameter int HOLD    = 2,
  parameter int GAP     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_CMD,
    S_SHIFT,
    S_HOLD,
    S_WAIT,
    S_CAPT,
    S_GAP
  } state_t;

  // Terminal counts; every phase counts up from 0 and stops at its last value.
  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] CAPT_LAST  = 4'd7;
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [9:0] frame;
  logic       is_read;
  logic [7:0] shreg;

  // Handshake and status are straight decodes of the state register.
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Sequencer. Each transition also loads ss_n/mosi for the state being
  // entered, so the pins always match the state of the current cycle.
  // The frame register shifts left during SHIFT; its MSB is the next bit out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      frame     <= 10'd0;
      is_read   <= 1'b0;
      shreg     <= 8'h00;
      ss_n      <= 1'b1;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            frame   <= {req_op, req_data};
            is_read <= &req_op;
            cnt     <= 4'd0;
            ss_n    <= 1'b0;
            mosi    <= 1'b0;
            state   <= S_SEL;
          end
        end
        S_SEL: begin
          // Command bit: frame[9] is 0 for writes and 1 for reads.
          mosi  <= frame[9];
          state <= S_CMD;
        end
        S_CMD: begin
          mosi  <= frame[9];
          frame <= {frame[8:0], 1'b0};
          cnt   <= 4'd0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            mosi  <= 1'b0;
            cnt   <= 4'd0;
            state <= is_read ? S_WAIT : S_HOLD;
          end else begin
            mosi  <= frame[9];
            frame <= {frame[8:0], 1'b0};
            cnt   <= cnt + 4'd1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            ss_n  <= 1'b1;
            cnt   <= 4'd0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= 4'd0;
            state <= S_CAPT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_CAPT: begin
          // The 8th sample goes straight into rsp_data on the same edge.
          shreg <= {shreg[6:0], miso};
          if (cnt == CAPT_LAST) begin
            rsp_data  <= {shreg[6:0], miso};
            rsp_valid <= 1'b1;
            ss_n      <= 1'b1;
            cnt       <= 4'd0;
            state     <= S_GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= 4'd0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          ss_n  <= 1'b1;
          mosi  <= 1'b0;
          cnt   <= 4'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_master_seq
//
// Two copies of spi_master_seq share one clock: cfg0 uses the default timing
// (RD_WAIT=3, HOLD=2, GAP=2), cfg1 the minimum timing (1, 1, 1). Each copy
// gets its own stimulus thread. A behavioural model builds the expected pin
// trace of every accepted frame from the frame rules and also plays the slave,
// driving MISO only in the cycles where a reply byte is due.
// -----------------------------------------------------------------------------
module tb_spi_master_seq;

  localparam int RW0 = 3, HL0 = 2, GP0 = 2;
  localparam int RW1 = 1, HL1 = 1, GP1 = 1;

  logic clk;

  logic [1:0]       rst_n, req_valid, req_ready, rsp_valid, busy, ss_n, mosi, miso;
  logic [1:0][1:0]  req_op;
  logic [1:0][7:0]  req_data, rsp_data;

  // Expected pins for one cycle: ss_n, mosi, rsp_valid, whether the slave
  // drives miso, the miso bit, and the byte carried by a response cycle.
  typedef struct packed {
    logic       ss;
    logic       mo;
    logic       rv;
    logic       drv;
    logic       mi;
    logic [7:0] rd;
  } exp_t;

  exp_t       wq [2][$];
  logic [7:0] rq [2][$];
  exp_t       cur [2];
  bit         idle_now [2];
  bit         known [2];
  logic [7:0] held [2];
  int         acc_cnt [2];
  logic [7:0] slave_byte [2];

  bit         rs_s [2];
  bit         ac_s [2];
  logic [1:0] op_s [2];
  logic [7:0] dat_s [2];
  logic [7:0] byte_s [2];

  int checks = 0;
  int errors = 0;

  // Both configurations, identical apart from their timing parameters.
  for (genvar g = 0; g < 2; g++) begin : g_cfg
    spi_master_seq #(
      .RD_WAIT((g == 0) ? RW0 : RW1),
      .HOLD   ((g == 0) ? HL0 : HL1),
      .GAP    ((g == 0) ? GP0 : GP1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_op   (req_op[g]),
      .req_data (req_data[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_data (rsp_data[g]),
      .busy     (busy[g]),
      .ss_n     (ss_n[g]),
      .mosi     (mosi[g]),
      .miso     (miso[g])
    );
  end

  // Free-running 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void checkOutput(string name, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL cfg%0d %s: got %0h, expected %0h at %0t", i, name, got, exp, $time);
    end
  endfunction

  function automatic exp_t mk(logic ss, logic mo);
    exp_t e;
    e    = '0;
    e.ss = ss;
    e.mo = mo;
    return e;
  endfunction

  // Expected trace of one frame, cycle by cycle from the first SEL cycle to
  // the last GAP cycle: dead cycle, command bit, 10 frame bits MSB first,
  // then either the hold tail or wait + 8 reply bits, then the gap.
  function automatic void pushFrame(int i, logic [1:0] op, logic [7:0] d, logic [7:0] b);
    logic [9:0] f;
    exp_t       e;
    int         rw, hl, gp;
    f  = {op, d};
    rw = (i == 0) ? RW0 : RW1;
    hl = (i == 0) ? HL0 : HL1;
    gp = (i == 0) ? GP0 : GP1;
    wq[i].push_back(mk(1'b0, 1'b0));
    wq[i].push_back(mk(1'b0, f[9]));
    for (int k = 9; k >= 0; k--) wq[i].push_back(mk(1'b0, f[k]));
    if (op == 2'b11) begin
      for (int k = 0; k < rw; k++) wq[i].push_back(mk(1'b0, 1'b0));
      for (int k = 0; k < 8; k++) begin
        e     = mk(1'b0, 1'b0);
        e.drv = 1'b1;
        e.mi  = b[7-k];
        wq[i].push_back(e);
      end
      rq[i].push_back(b);
    end else begin
      for (int k = 0; k < hl; k++) wq[i].push_back(mk(1'b0, 1'b0));
    end
    for (int k = 0; k < gp; k++) begin
      e = mk(1'b1, 1'b0);
      if (k == 0 && op == 2'b11) begin
        e.rv = 1'b1;
        e.rd = b;
      end
      wq[i].push_back(e);
    end
  endfunction

  function automatic void checkCycle(int i);
    checkOutput("ss_n", i, ss_n[i], cur[i].ss);
    checkOutput("mosi", i, mosi[i], cur[i].mo);
    checkOutput("rsp_valid", i, rsp_valid[i], cur[i].rv);
    checkOutput("req_ready", i, req_ready[i], idle_now[i]);
    checkOutput("busy", i, busy[i], !idle_now[i]);
    checkOutput("rsp_data_held", i, rsp_data[i], held[i]);
    if (rsp_valid[i] === 1'b1) begin
      if (rq[i].size() == 0) checkOutput("rsp_unexpected", i, 1, 0);
      else checkOutput("rsp_byte", i, rsp_data[i], rq[i].pop_front());
    end
  endfunction

  // Model clocking: at each edge it records reset and whether a command is
  // accepted (idle cycle, valid high, out of reset); just after the edge it
  // advances the expected trace and drives MISO; at the falling edge the pins
  // are compared with the trace.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        rs_s[i]   = (rst_n[i] === 1'b1);
        ac_s[i]   = (rst_n[i] === 1'b1) && (req_valid[i] === 1'b1) && known[i] && idle_now[i];
        op_s[i]   = req_op[i];
        dat_s[i]  = req_data[i];
        byte_s[i] = slave_byte[i];
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!rs_s[i]) begin
          wq[i].delete();
          rq[i].delete();
          held[i]     = 8'h00;
          known[i]    = 1'b1;
          cur[i]      = mk(1'b1, 1'b0);
          idle_now[i] = 1'b1;
        end else if (known[i]) begin
          if (ac_s[i]) begin
            pushFrame(i, op_s[i], dat_s[i], byte_s[i]);
            acc_cnt[i]++;
          end
          if (wq[i].size() > 0) begin
            cur[i]      = wq[i].pop_front();
            idle_now[i] = 1'b0;
          end else begin
            cur[i]      = mk(1'b1, 1'b0);
            idle_now[i] = 1'b1;
          end
          if (cur[i].rv) held[i] = cur[i].rd;
        end
        miso[i] = cur[i].drv ? cur[i].mi : 1'($urandom);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (known[i]) checkCycle(i);
    end
  end

  // Present one command and hold it until the model sees it accepted.
  task automatic applyStimulus(int i, logic [1:0] op, logic [7:0] d, logic [7:0] b);
    int n0, guard;
    slave_byte[i] = b;
    req_op[i]     = op;
    req_data[i]   = d;
    req_valid[i]  = 1'b1;
    n0            = acc_cnt[i];
    guard         = 0;
    while (acc_cnt[i] == n0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_seen", i, (acc_cnt[i] != n0), 1);
  endtask

  // Random request noise, only while a frame is in progress.
  task automatic noiseWhileBusy(int i, int n);
    repeat (n) begin
      if (!idle_now[i]) begin
        req_valid[i] = 1'($urandom);
        req_op[i]    = 2'($urandom);
        req_data[i]  = 8'($urandom);
      end else begin
        req_valid[i] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitIdle(int i);
    int guard;
    req_valid[i] = 1'b0;
    guard = 0;
    while (!idle_now[i] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("idle_reached", i, idle_now[i], 1);
  endtask

  task automatic resetPulse(int i);
    req_valid[i] = 1'b0;
    rst_n[i]     = 1'b0;
    @(negedge clk);
    rst_n[i]     = 1'b1;
  endtask

  // Directed frames from the test plan followed by a random mix of commands,
  // busy-time noise, back-to-back requests and occasional mid-frame resets.
  task automatic runInstance(int i);
    rst_n[i]      = 1'b0;
    req_valid[i]  = 1'b1;
    req_op[i]     = 2'($urandom);
    req_data[i]   = 8'($urandom);
    slave_byte[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[i]     = 1'b1;
    req_valid[i] = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(i, 2'b00, 8'hA5, 8'h00);
    waitIdle(i);
    applyStimulus(i, 2'b11, 8'h80, 8'h3C);
    waitIdle(i);

    applyStimulus(i, 2'b10, 8'($urandom), 8'($urandom));
    applyStimulus(i, 2'b11, 8'($urandom), 8'($urandom));
    waitIdle(i);

    // Reset lands on the edge that ends SHIFT bit 5 (accept + 8 cycles).
    applyStimulus(i, 2'b01, 8'($urandom), 8'($urandom));
    req_valid[i] = 1'b0;
    repeat (7) @(negedge clk);
    resetPulse(i);
    applyStimulus(i, 2'b01, 8'hFF, 8'($urandom));
    waitIdle(i);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(i, 2'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        req_valid[i] = 1'b0;
        repeat ($urandom_range(0, 20)) @(negedge clk);
        resetPulse(i);
      end else begin
        noiseWhileBusy(i, $urandom_range(0, 25));
        if ($urandom_range(0, 1) == 1) waitIdle(i);
      end
    end
    waitIdle(i);
    repeat (3) @(negedge clk);
    checkOutput("rsp_outstanding", i, rq[i].size(), 0);
  endtask

  // Top-level sequence: run both configurations side by side, then report.
  initial begin
    fork
      runInstance(0);
      runInstance(1);
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a thread never returns.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
